barrel_spawn_ctl: RTL

- Parametrised successor of the per-direction barrel controller.
- Manages a pool of CHANNELS barrel slots: allocates the lowest free slot on a player-2 trigger (key edge or optional auto timer) and enforces a cooldown between spawns and a cap on simultaneously active barrels.
- Releases slots on the barrel movers' done pulses.
- Sits between the UART key decoder / game-state signals and the per-barrel movement blocks; drives their enable mask.

---
 rtl/barrel_spawn_ctl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/barrel_spawn_ctl.sv
// rtl/barrel_spawn_ctl.sv - barrel slot pool: allocate on key edge or auto timer, release on done
// Cooldown between spawns, cap on simultaneously active slots.
module barrel_spawn_ctl #(
    parameter int CHANNELS    = 5,
    parameter int DELAY_TIME  = 162_500_000,
    parameter int MAX_ACTIVE  = 5,
    parameter int AUTO_PERIOD = 0,
    parameter int CNT_W       = 28,
    localparam int IDX_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int ACT_W      = $clog2(CHANNELS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_game_i,
    input  logic                animation_i,
    input  logic                key_i,
    input  logic                auto_en_i,
    input  logic [CHANNELS-1:0] done_i,
    output logic [CHANNELS-1:0] barrel_o,
    output logic                spawn_o,
    output logic [IDX_W-1:0]    spawn_idx_o,
    output logic [ACT_W-1:0]    active_cnt_o,
    output logic                ready_o
);

    localparam int AUTO_LAST = (AUTO_PERIOD > 0) ? AUTO_PERIOD - 1 : 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ANIM = 2'd1,
        ARMED     = 2'd2,
        COOLDOWN  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                key_q;
    logic                pending_q, pending_d;
    logic [CNT_W-1:0]    cooldown_q, cooldown_d;
    logic [CNT_W-1:0]    auto_cnt_q, auto_cnt_d;
    logic [CHANNELS-1:0] barrel_q, barrel_d;
    logic [ACT_W-1:0]    active_cnt_q, active_cnt_d;
    logic                spawn_q, spawn_d;
    logic [IDX_W-1:0]    spawn_idx_q, spawn_idx_d;

    logic                req_key;
    logic                free_found;
    logic [IDX_W-1:0]    free_idx;
    logic                alloc;
    logic                auto_run;
    logic                auto_wrap;
    logic [CHANNELS-1:0] alloc_mask;

    assign req_key = key_i & ~key_q;

    // Searching downward makes the last hit the lowest free slot.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (!barrel_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign alloc = (state_q == ARMED) && (req_key || pending_q) && free_found
                   && (active_cnt_q < ACT_W'(MAX_ACTIVE));

    assign auto_run  = (AUTO_PERIOD > 0) && auto_en_i
                       && ((state_q == ARMED) || (state_q == COOLDOWN));
    assign auto_wrap = auto_run && (auto_cnt_q == CNT_W'(AUTO_LAST));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!start_game_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = WAIT_ANIM;
                WAIT_ANIM: if (!animation_i) state_d = ARMED;
                ARMED:     if (alloc) state_d = COOLDOWN;
                COOLDOWN:  if (cooldown_q == '0) state_d = ARMED;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o = (state_q == ARMED);
    end

    // Releases act on the old mask; a slot freed this cycle cannot be picked until the next one.
    always_comb begin
        alloc_mask  = alloc ? (CHANNELS'(1) << free_idx) : '0;
        barrel_d    = (barrel_q & ~done_i) | alloc_mask;
        spawn_d     = alloc;
        spawn_idx_d = alloc ? free_idx : spawn_idx_q;

        cooldown_d = cooldown_q;
        if (alloc) begin
            cooldown_d = CNT_W'(DELAY_TIME - 1);
        end else if ((state_q == COOLDOWN) && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - CNT_W'(1);
        end

        if (!auto_run) begin
            auto_cnt_d = '0;
            pending_d  = 1'b0;
        end else begin
            auto_cnt_d = auto_wrap ? '0 : auto_cnt_q + CNT_W'(1);
            pending_d  = auto_wrap ? 1'b1 : (alloc ? 1'b0 : pending_q);
        end

        if (!start_game_i) begin
            barrel_d   = '0;
            spawn_d    = 1'b0;
            cooldown_d = '0;
            auto_cnt_d = '0;
            pending_d  = 1'b0;
        end
    end

    always_comb begin
        active_cnt_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            active_cnt_d = active_cnt_d + ACT_W'(barrel_d[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_q        <= 1'b0;
            pending_q    <= 1'b0;
            cooldown_q   <= '0;
            auto_cnt_q   <= '0;
            barrel_q     <= '0;
            active_cnt_q <= '0;
            spawn_q      <= 1'b0;
            spawn_idx_q  <= '0;
        end else begin
            key_q        <= key_i;
            pending_q    <= pending_d;
            cooldown_q   <= cooldown_d;
            auto_cnt_q   <= auto_cnt_d;
            barrel_q     <= barrel_d;
            active_cnt_q <= active_cnt_d;
            spawn_q      <= spawn_d;
            spawn_idx_q  <= spawn_idx_d;
        end
    end

    assign barrel_o     = barrel_q;
    assign spawn_o      = spawn_q;
    assign spawn_idx_o  = spawn_idx_q;
    assign active_cnt_o = active_cnt_q;

endmodule
